wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Downstream observer of the pipeline's write-back stage.
- Consumes the final write-back triple (write data, destination register, regwrite strobe) that the datapath drives out every cycle.
- Each qualified register write is captured into a sequence-numbered FIFO entry and drained through a valid/ready port to a testbench scoreboard, debug UART or logic analyser.
- Keeps retired-write and dropped-entry counters so software and verification can detect lost trace entries.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- FILTER_R0, 1, when 1, writes to register 0 are not traced.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- wb_regwrite  input  1  write-back register-write strobe from MEM/WB.
- wb_dest  input  5  write-back destination register address.
- wb_data  input  32  final write-back data (after the memtoreg and lui muxes).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry this cycle.
- out_dest  output  5  head entry destination register.
- out_data  output  32  head entry data.
- out_seq  output  16  head entry sequence number.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- write_cnt  output  32  total qualified writes seen; wraps modulo 2^32.
- overflow_cnt  output  16  qualified writes dropped because the FIFO was full; saturates at 16'hFFFF.

Behaviour:
- Synchronous, active-high reset, evaluated on the CLK rising edge. RESET has priority over every other event, including a push or pop in the same cycle. Reset values:
  - rd_ptr = 0, wr_ptr = 0, count = 0, seq = 0
  - write_cnt = 0, overflow_cnt = 0
  - out_valid = 0, empty = 1, full = 0
  - out_dest = 0, out_data = 0, out_seq = 0
- A reset asserted mid-operation discards all stored entries. Inputs are ignored while RESET is high.
- Qualified write (q): wb_regwrite == 1 AND NOT (FILTER_R0 == 1 AND wb_dest == 0).
- Pop (p): out_valid AND out_ready. out_ready with out_valid == 0 has no effect.
- Every q, accepted or dropped:
  - increments write_cnt;
  - consumes the current seq value;
  - increments seq by 1, wrapping 16'hFFFF to 0.
  - Dropped entries therefore appear as gaps in out_seq.
- Push: the entry {wb_dest, wb_data, seq} is written at wr_ptr and wr_ptr increments modulo DEPTH. It happens when q and either:
  - not full, or
  - full and p in the same cycle (simultaneous pop frees the slot).
- Drop: q and full and not p. Entry is discarded and overflow_cnt increments unless already 16'hFFFF.
- On p, rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on push without pop
  - -1 on pop without push
  - unchanged on push and pop together, or on neither.
- Output timing:
  - Registered storage, no combinational bypass. An entry pushed in cycle N is visible on out_* at the earliest in cycle N+1 (1-cycle latency).
  - out_valid = !empty.
  - out_dest, out_data, out_seq show the entry at rd_ptr when out_valid = 1, and are driven to 0 when empty.
  - full and empty are derived from count and valid in the same cycle as count.
- Push and pop when count == 1: the old head leaves and the new entry becomes the head next cycle. out_valid stays 1.
- Pointer wrap-around is transparent. Entry order is strict FIFO across the wrap.
- No internal state machine beyond pointer/count bookkeeping. The block never backpressures the pipeline; it drops and counts instead.

Test Plan:
- Reset then idle: RESET high for 2 cycles, then 5 idle cycles -> out_valid = 0, empty = 1, count = 0, write_cnt = 0, overflow_cnt = 0, out_data = 0.
- Single capture: wb_regwrite = 1, wb_dest = 5'd8, wb_data = 32'hDEADBEEF for one cycle, out_ready = 0:
  - next cycle out_valid = 1, out_dest = 8, out_data = 32'hDEADBEEF, out_seq = 0, count = 1;
  - assert out_ready one cycle -> empty = 1.
- R0 filter: FILTER_R0 = 1, write wb_dest = 0, data = 32'h1234 -> no entry, write_cnt unchanged, seq unchanged. Repeat with FILTER_R0 = 0 -> entry with out_dest = 0, out_seq = 0.
- Overflow: out_ready = 0, 18 consecutive writes to r9, data = i (0..17):
  - count = 16, full = 1, overflow_cnt = 2, write_cnt = 18;
  - drain -> out_data 0..15 with out_seq 0..15;
  - the next write then gets out_seq = 18 (gap proves the drops).
- Full with simultaneous push/pop: FIFO full, out_ready = 1 and a qualified write (data 32'hA5A5A5A5) in the same cycle -> no drop, overflow_cnt unchanged, count stays 16, 32'hA5A5A5A5 emerges 16th in drain order.
- Wrap and mid-operation reset:
  - alternating push/pop for 40 cycles -> pointers wrap, out_seq strictly increasing, count in {0,1};
  - then fill 5 entries and pulse RESET together with a push -> next cycle count = 0, out_valid = 0, seq restarts at 0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures qualified register writes with a sequence
// number and drains them over a valid/ready port, counting retired and dropped writes.
module wb_trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int FILTER_R0 = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_dest,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_dest,
    output logic [31:0]       out_data,
    output logic [15:0]       out_seq,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [31:0]       write_cnt,
    output logic [15:0]       overflow_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [4:0]        mem_dest [0:DEPTH-1];
    logic [31:0]       mem_data [0:DEPTH-1];
    logic [15:0]       mem_seq  [0:DEPTH-1];

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [15:0]       seq;

    logic              qual;
    logic              pop;
    logic              push;
    logic              drop;

    assign qual = wb_regwrite && !((FILTER_R0 == 1) && (wb_dest == 5'd0));
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push = qual && (!full || pop);
    assign drop = qual && full && !pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = !empty;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_dest[wr_ptr] <= wb_dest;
            mem_data[wr_ptr] <= wb_data;
            mem_seq[wr_ptr]  <= seq;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            seq          <= '0;
            write_cnt    <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (qual) begin
                seq       <= seq + 16'd1;
                write_cnt <= write_cnt + 32'd1;
            end
            if (drop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_dest = '0;
        out_data = '0;
        out_seq  = '0;
        if (!empty) begin
            out_dest = mem_dest[rd_ptr];
            out_data = mem_data[rd_ptr];
            out_seq  = mem_seq[rd_ptr];
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo; a second instance with the
// register-0 filter disabled shares the same stimulus.
module tb_wb_trace_fifo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        out_ready;

    logic        out_valid, full, empty;
    logic [4:0]  out_dest;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic [31:0] write_cnt;
    logic [15:0] overflow_cnt;

    logic        out_valid_b, full_b, empty_b;
    logic [4:0]  out_dest_b;
    logic [31:0] out_data_b;
    logic [15:0] out_seq_b;
    logic [4:0]  count_b;
    logic [31:0] write_cnt_b;
    logic [15:0] overflow_cnt_b;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    logic [15:0] exp_seq;

    always #5 CLK = ~CLK;

    wb_trace_fifo #(.DEPTH(16), .ADDR_W(4), .FILTER_R0(1)) dut (
        .CLK(CLK), .RESET(RESET), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_dest(out_dest), .out_data(out_data), .out_seq(out_seq), .count(count),
        .full(full), .empty(empty), .write_cnt(write_cnt), .overflow_cnt(overflow_cnt)
    );

    wb_trace_fifo #(.DEPTH(16), .ADDR_W(4), .FILTER_R0(0)) dut_nofilt (
        .CLK(CLK), .RESET(RESET), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_data(wb_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_dest(out_dest_b), .out_data(out_data_b), .out_seq(out_seq_b), .count(count_b),
        .full(full_b), .empty(empty_b), .write_cnt(write_cnt_b), .overflow_cnt(overflow_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic write1(input logic [4:0] d, input logic [31:0] v);
        wb_regwrite = 1'b1;
        wb_dest     = d;
        wb_data     = v;
        tick();
        wb_regwrite = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; wb_regwrite = 1'b0; wb_dest = '0; wb_data = '0; out_ready = 1'b0;
        #1;
        tick(); tick();
        RESET = 1'b0;
        repeat (5) tick();
        check("rst_valid", out_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_wcnt", write_cnt, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_data", out_data, 0);
        check("rst_seq", out_seq, 0);

        // single capture
        write1(5'd8, 32'hDEADBEEF);
        check("cap_valid", out_valid, 1);
        check("cap_dest", out_dest, 8);
        check("cap_data", out_data, 32'hDEADBEEF);
        check("cap_seq", out_seq, 0);
        check("cap_count", count, 1);
        check("cap_wcnt", write_cnt, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("pop_empty", empty, 1);
        check("pop_valid", out_valid, 0);
        check("pop_data", out_data, 0);

        // register-0 filter, both settings from a clean reset
        do_reset();
        write1(5'd0, 32'h1234);
        check("r0f_empty", empty, 1);
        check("r0f_wcnt", write_cnt, 0);
        check("r0n_valid", out_valid_b, 1);
        check("r0n_dest", out_dest_b, 0);
        check("r0n_data", out_data_b, 32'h1234);
        check("r0n_seq", out_seq_b, 0);
        write1(5'd3, 32'h77);
        check("r0f_seq_kept", out_seq, 0);
        check("r0f_data", out_data, 32'h77);
        check("r0n_count", count_b, 2);

        // overflow: 18 writes into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 18; i++) write1(5'd9, 32'(i));
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        check("ovf_ovf", overflow_cnt, 2);
        check("ovf_wcnt", write_cnt, 18);
        check("ovf_head_data", out_data, 0);
        check("ovf_head_seq", out_seq, 0);

        // full with simultaneous push and pop: no drop
        out_ready = 1'b1;
        write1(5'd9, 32'hA5A5A5A5);
        out_ready = 1'b0;
        check("fpp_ovf", overflow_cnt, 2);
        check("fpp_count", count, 16);
        check("fpp_wcnt", write_cnt, 19);
        check("fpp_head", out_data, 1);

        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drn_valid", out_valid, 1);
            check("drn_data", out_data, (k < 15) ? 32'(k + 1) : 32'hA5A5A5A5);
            check("drn_seq", out_seq, (k < 15) ? 32'(k + 1) : 32'd18);
            tick();
        end
        out_ready = 1'b0;
        check("drn_empty", empty, 1);
        write1(5'd9, 32'hC0FFEE);
        check("post_seq", out_seq, 19);

        // alternating push/pop across pointer wrap
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("alt_start_empty", empty, 1);
        exp_seq = 16'd20;
        for (int i = 0; i < 20; i++) begin
            write1(5'd4, 32'h100 + 32'(i));
            check("alt_count1", count, 1);
            check("alt_seq", out_seq, exp_seq);
            check("alt_data", out_data, 32'h100 + 32'(i));
            exp_seq = exp_seq + 16'd1;
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            check("alt_count0", count, 0);
        end

        // mid-operation reset colliding with a push
        for (int i = 0; i < 5; i++) write1(5'd6, 32'h200 + 32'(i));
        check("mid_count", count, 5);
        RESET = 1'b1;
        write1(5'd6, 32'h999);
        RESET = 1'b0;
        check("mrst_count", count, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_wcnt", write_cnt, 0);
        check("mrst_ovf", overflow_cnt, 0);
        write1(5'd6, 32'h55);
        check("mrst_seq", out_seq, 0);
        check("mrst_data", out_data, 32'h55);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
